fetch_queue: RTL and testbench

- Instruction fetch stage placed directly upstream of the decode/register-file stage.
- Owns the fetch program counter and drives the combinational instruction memory address.
- Captures each fetched word, with its PC, into a small prefetch FIFO.
- Presents instructions to decode through a valid/ready handshake; branch/jump redirects flush the FIFO and restart fetch.

---
 rtl/fetch_queue.sv | 82 ++++++++
 tb/tb_fetch_queue.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the fetch PC and buffers fetched words
// in a small prefetch FIFO feeding decode over a valid/ready handshake.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_en,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_pc_plus4,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic pop;
    logic push;
    logic unused_redirect_lsbs;

    // Low address bits of a redirect target are forced to a word boundary.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign imem_addr    = fetch_pc;
    assign out_valid    = (count != '0);
    assign out_instr    = instr_mem[rd_ptr];
    assign out_pc       = pc_mem[rd_ptr];
    assign out_pc_plus4 = out_pc + 32'd4;

    assign pop  = out_valid & out_ready;
    assign push = fetch_en & ~redirect & ((count < FULL) | pop);

    // Storage needs no reset: entries are only observed once count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= imem_instr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
                wr_ptr   <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed vector table plus reset, priority and random-ready sequences
// for the fetch_queue prefetch FIFO.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  count;

    int passed = 0;
    int total  = 0;

    fetch_queue dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_en     (fetch_en),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .out_pc       (out_pc),
        .out_pc_plus4 (out_pc_plus4),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .count        (count)
    );

    always #5 clk = ~clk;

    // Address-tagged instruction memory
    assign imem_instr = 32'hA000_0000 | imem_addr;

    typedef struct {
        logic        fe;
        logic        rdy;
        logic        rd;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [2:0]  ecnt;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, " out_pc"}, out_pc, pc);
        chk({tag, " out_instr"}, out_instr, 32'hA000_0000 | pc);
        chk({tag, " out_pc_plus4"}, out_pc_plus4, pc + 32'd4);
    endtask

    logic [31:0] q[$];
    logic [31:0] mpc;
    logic        mpop;
    logic        mpush;

    initial begin
        vecs[0]  = '{1, 1, 0, 0,            1, 32'h0,         1, 32'h4};
        vecs[1]  = '{1, 1, 0, 0,            1, 32'h4,         1, 32'h8};
        vecs[2]  = '{1, 1, 0, 0,            1, 32'h8,         1, 32'hC};
        vecs[3]  = '{1, 0, 0, 0,            1, 32'h8,         2, 32'h10};
        vecs[4]  = '{1, 0, 0, 0,            1, 32'h8,         3, 32'h14};
        vecs[5]  = '{1, 0, 0, 0,            1, 32'h8,         4, 32'h18};
        vecs[6]  = '{1, 0, 0, 0,            1, 32'h8,         4, 32'h18};
        vecs[7]  = '{1, 1, 0, 0,            1, 32'hC,         4, 32'h1C};
        vecs[8]  = '{0, 1, 0, 0,            1, 32'h10,        3, 32'h1C};
        vecs[9]  = '{0, 0, 0, 0,            1, 32'h10,        3, 32'h1C};
        vecs[10] = '{1, 0, 1, 32'h103,      0, 32'h0,         0, 32'h100};
        vecs[11] = '{1, 1, 0, 0,            1, 32'h100,       1, 32'h104};
        vecs[12] = '{1, 1, 1, 32'hFFFFFFFA, 0, 32'h0,         0, 32'hFFFFFFF8};
        vecs[13] = '{1, 1, 0, 0,            1, 32'hFFFFFFF8,  1, 32'hFFFFFFFC};
        vecs[14] = '{1, 1, 0, 0,            1, 32'hFFFFFFFC,  1, 32'h0};
        vecs[15] = '{1, 1, 0, 0,            1, 32'h0,         1, 32'h4};
        vecs[16] = '{0, 1, 0, 0,            0, 32'h0,         0, 32'h4};
        vecs[17] = '{0, 1, 0, 0,            0, 32'h0,         0, 32'h4};

        rst = 1'b1;
        fetch_en = 1'b0;
        out_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        #12;
        chk("reset out_valid", {31'b0, out_valid}, 32'h0);
        chk("reset imem_addr", imem_addr, 32'h0);
        chk("reset count", {29'b0, count}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            fetch_en    = vecs[i].fe;
            out_ready   = vecs[i].rdy;
            redirect    = vecs[i].rd;
            redirect_pc = vecs[i].rpc;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d out_valid", i), {31'b0, out_valid},
                {31'b0, vecs[i].ev});
            chk($sformatf("v%0d count", i), {29'b0, count},
                {29'b0, vecs[i].ecnt});
            chk($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].eaddr);
            if (vecs[i].ev) chk_head($sformatf("v%0d", i), vecs[i].epc);
        end

        // Asynchronous reset between edges while streaming
        @(negedge clk);
        fetch_en = 1'b1;
        out_ready = 1'b1;
        redirect = 1'b0;
        @(posedge clk);
        #1;
        chk("pre-rst out_valid", {31'b0, out_valid}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst out_valid", {31'b0, out_valid}, 32'h0);
        chk("async rst imem_addr", imem_addr, 32'h0);
        chk("async rst count", {29'b0, count}, 32'h0);

        // Reset outranks a concurrent redirect
        redirect = 1'b1;
        redirect_pc = 32'h40;
        @(posedge clk);
        #1;
        chk("rst+redirect imem_addr", imem_addr, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        redirect = 1'b0;
        @(posedge clk);
        #1;
        chk("restart out_valid", {31'b0, out_valid}, 32'h1);
        chk_head("restart", 32'h0);

        q = {32'h0};
        mpc = 32'h4;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            fetch_en  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) == 1);
            mpop  = (q.size() != 0) && out_ready;
            mpush = fetch_en && ((q.size() < 4) || mpop);
            @(posedge clk);
            if (mpop) void'(q.pop_front());
            if (mpush) begin
                q.push_back(mpc);
                mpc = mpc + 32'd4;
            end
            #1;
            chk($sformatf("r%0d count", c), {29'b0, count}, q.size());
            chk($sformatf("r%0d imem_addr", c), imem_addr, mpc);
            if (q.size() != 0) chk_head($sformatf("r%0d", c), q[0]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
